// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types, default clip map and helpers for the sfx clip sequencer
//
// Contents:
//   sfx_state_e            : sequencer FSM states (IDLE/PLAY)
//   SFX_ID_*               : clip id constants for the default audio ROM image
//   SFX_*_START / SFX_*_END: default clip boundaries (inclusive) in the audio ROM
//   SFX_CLIP_*_DEFAULT     : the default map packed as NUM_CLIPS x ADDR_W, clip 0 in the LSBs
//   SFX_DIV_DEFAULT        : CLOCK_50 cycles per audio sample (50 MHz / 1200 ~ 41.7 kHz)
//   sfx_cnt_w()            : counter width for a divide-by-n counter
package sfx_pkg;

    typedef enum logic [0:0] {
        SFX_IDLE = 1'b0,
        SFX_PLAY = 1'b1
    } sfx_state_e;

    localparam int SFX_ADDR_W      = 18;
    localparam int SFX_NUM_CLIPS   = 4;
    localparam int SFX_DIV_DEFAULT = 1200;

    localparam logic [1:0] SFX_ID_WIN    = 2'd0;
    localparam logic [1:0] SFX_ID_MOO    = 2'd1;
    localparam logic [1:0] SFX_ID_DETECT = 2'd2;
    localparam logic [1:0] SFX_ID_CHEER  = 2'd3;

    localparam logic [SFX_ADDR_W-1:0] SFX_WIN_START    = 18'd0;
    localparam logic [SFX_ADDR_W-1:0] SFX_WIN_END      = 18'd16395;
    localparam logic [SFX_ADDR_W-1:0] SFX_MOO_START    = 18'd16396;
    localparam logic [SFX_ADDR_W-1:0] SFX_MOO_END      = 18'd66982;
    localparam logic [SFX_ADDR_W-1:0] SFX_DETECT_START = 18'd66983;
    localparam logic [SFX_ADDR_W-1:0] SFX_DETECT_END   = 18'd83254;
    localparam logic [SFX_ADDR_W-1:0] SFX_CHEER_START  = 18'd83255;
    localparam logic [SFX_ADDR_W-1:0] SFX_CHEER_END    = 18'd137138;

    localparam logic [SFX_NUM_CLIPS*SFX_ADDR_W-1:0] SFX_CLIP_START_DEFAULT =
        {SFX_CHEER_START, SFX_DETECT_START, SFX_MOO_START, SFX_WIN_START};
    localparam logic [SFX_NUM_CLIPS*SFX_ADDR_W-1:0] SFX_CLIP_END_DEFAULT =
        {SFX_CHEER_END, SFX_DETECT_END, SFX_MOO_END, SFX_WIN_END};

    function automatic int sfx_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sfx_tick_div.sv
// rtl/sfx_tick_div.sv - divide-by-DIV down-counter producing a one-cycle tick
//
// Parameters:
//   DIV      : enabled cycles between ticks
// Ports:
//   CLOCK_50 : system clock
//   resetn   : synchronous active-low reset
//   clr_i    : reload the counter; the first tick follows DIV enabled cycles later
//   en_i     : count enable; the counter holds while low
//   tick_o   : high for the one enabled cycle in every DIV in which the count reaches zero
module sfx_tick_div
    import sfx_pkg::*;
#(
    parameter int DIV = SFX_DIV_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int               CNT_W = sfx_cnt_w(DIV);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                tick_o = 1'b1;
                cnt_d  = LOAD;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sfx_clip_sequencer.sv
// rtl/sfx_clip_sequencer.sv - multi-clip sound effect sequencer in front of the audio ROM
//
// Plays one of NUM_CLIPS clips stored back-to-back in a single audio ROM, one
// sample every DIV cycles, with play-once/loop, priority preemption and stop.
// Optional macro SFX_QUEUE_EN adds a one-deep pending slot for lower-priority
// triggers, started right after the current play-once clip completes.
//
// Ports:
//   CLOCK_50     : system clock
//   resetn       : synchronous active-low reset
//   trig         : one-cycle start request, with trig_id / trig_loop
//   stop         : abort playback (wins over trig)
//   rom_addr     : audio ROM address
//   rom_q        : audio ROM data, valid ROM_LAT cycles after the address
//   sample       : {rom_q, zeros} left-justified, holds between strobes
//   sample_valid : one-cycle strobe when sample updates
//   busy         : high while playing
//   cur_id       : id of the clip playing (or last played)
//   done         : one-cycle pulse with the last sample of a play-once clip
module sfx_clip_sequencer
    import sfx_pkg::*;
#(
    parameter int ADDR_W    = SFX_ADDR_W,
    parameter int DATA_W    = 6,
    parameter int NUM_CLIPS = SFX_NUM_CLIPS,
    parameter int ID_W      = 2,
    parameter int DIV       = SFX_DIV_DEFAULT,
    parameter int ROM_LAT   = 1,
    parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_START = SFX_CLIP_START_DEFAULT,
    parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_END   = SFX_CLIP_END_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              trig,
    input  logic [ID_W-1:0]   trig_id,
    input  logic              trig_loop,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [31:0]       sample,
    output logic              sample_valid,
    output logic              busy,
    output logic [ID_W-1:0]   cur_id,
    output logic              done
);

    generate
        for (genvar g = 0; g < NUM_CLIPS; g++) begin : g_clip_chk
            if (CLIP_START[g*ADDR_W +: ADDR_W] > CLIP_END[g*ADDR_W +: ADDR_W]) begin : g_bad_clip
                $error("sfx_clip_sequencer: clip %0d has start > end", g);
            end
        end
        if (ROM_LAT < 1) begin : g_bad_lat
            $error("sfx_clip_sequencer: ROM_LAT must be at least 1");
        end
        if (ID_W < sfx_cnt_w(NUM_CLIPS)) begin : g_bad_id_w
            $error("sfx_clip_sequencer: ID_W too narrow for NUM_CLIPS");
        end
    endgenerate

    function automatic logic [ADDR_W-1:0] clip_start(input logic [ID_W-1:0] id);
        return CLIP_START[32'(id)*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] clip_end(input logic [ID_W-1:0] id);
        return CLIP_END[32'(id)*ADDR_W +: ADDR_W];
    endfunction

    sfx_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              loop_q, loop_d;
    // Final tick of a play-once clip issued; waiting for its sample to emerge.
    logic              ending_q, ending_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    // Read pipeline: a valid bit per outstanding read plus a "last sample" marker.
    logic [ROM_LAT-1:0] pv_q, pv_d;
    logic [ROM_LAT-1:0] pl_q, pl_d;
`ifdef SFX_QUEUE_EN
    logic              pend_v_q, pend_v_d;
    logic [ID_W-1:0]   pend_id_q, pend_id_d;
    logic              pend_loop_q, pend_loop_d;
`endif

    logic            tick;
    logic            div_clr;
    logic            div_en;
    logic            trig_ok;
    logic            out_valid;
    logic            done_w;
    logic            start_go;
    logic [ID_W-1:0] start_id;
    logic            start_loop;

    assign trig_ok   = trig && (32'(trig_id) < 32'(NUM_CLIPS));
    assign out_valid = pv_q[ROM_LAT-1];
    assign done_w    = pv_q[ROM_LAT-1] & pl_q[ROM_LAT-1];
    assign div_en    = (state_q == SFX_PLAY) && !ending_q;

    sfx_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .clr_i    (div_clr),
        .en_i     (div_en),
        .tick_o   (tick)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        loop_d     = loop_q;
        ending_d   = ending_q;
        hold_d     = out_valid ? rom_q : hold_q;
        pv_d       = pv_q << 1;
        pl_d       = pl_q << 1;
        div_clr    = 1'b0;
        start_go   = 1'b0;
        start_id   = trig_id;
        start_loop = trig_loop;
`ifdef SFX_QUEUE_EN
        pend_v_d    = pend_v_q;
        pend_id_d   = pend_id_q;
        pend_loop_d = pend_loop_q;
`endif
        if (stop) begin
            state_d  = SFX_IDLE;
            pv_d     = '0;
            pl_d     = '0;
            hold_d   = '0;
            ending_d = 1'b0;
            div_clr  = 1'b1;
`ifdef SFX_QUEUE_EN
            pend_v_d = 1'b0;
`endif
        end else begin
            case (state_q)
                SFX_IDLE: begin
                    if (trig_ok) begin
                        start_go = 1'b1;
                    end
                end
                SFX_PLAY: begin
                    if (trig_ok && (trig_id >= id_q)) begin
                        // Preempt: reads in flight still deliver, but the old
                        // clip must never raise done.
                        start_go = 1'b1;
                        pl_d     = '0;
                    end else begin
                        if (tick) begin
                            pv_d[0] = 1'b1;
                            if (addr_q == clip_end(id_q)) begin
                                if (loop_q) begin
                                    addr_d = clip_start(id_q);
                                end else begin
                                    ending_d = 1'b1;
                                    pl_d[0]  = 1'b1;
                                end
                            end else begin
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        end
`ifdef SFX_QUEUE_EN
                        if (trig_ok) begin
                            pend_v_d    = 1'b1;
                            pend_id_d   = trig_id;
                            pend_loop_d = trig_loop;
                        end
`endif
                        if (done_w) begin
                            ending_d = 1'b0;
`ifdef SFX_QUEUE_EN
                            if (pend_v_d) begin
                                start_go   = 1'b1;
                                start_id   = pend_id_d;
                                start_loop = pend_loop_d;
                                pend_v_d   = 1'b0;
                            end else begin
                                state_d = SFX_IDLE;
                            end
`else
                            state_d = SFX_IDLE;
`endif
                        end
                    end
                end
                default: state_d = SFX_IDLE;
            endcase
        end

        if (start_go) begin
            state_d  = SFX_PLAY;
            addr_d   = clip_start(start_id);
            id_d     = start_id;
            loop_d   = start_loop;
            ending_d = 1'b0;
            div_clr  = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q  <= SFX_IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            loop_q   <= 1'b0;
            ending_q <= 1'b0;
            hold_q   <= '0;
            pv_q     <= '0;
            pl_q     <= '0;
`ifdef SFX_QUEUE_EN
            pend_v_q    <= 1'b0;
            pend_id_q   <= '0;
            pend_loop_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            loop_q   <= loop_d;
            ending_q <= ending_d;
            hold_q   <= hold_d;
            pv_q     <= pv_d;
            pl_q     <= pl_d;
`ifdef SFX_QUEUE_EN
            pend_v_q    <= pend_v_d;
            pend_id_q   <= pend_id_d;
            pend_loop_q <= pend_loop_d;
`endif
        end
    end

    // Sample is presented in the strobe cycle itself, then held.
    assign sample       = {(out_valid ? rom_q : hold_q), {(32-DATA_W){1'b0}}};
    assign sample_valid = out_valid;
    assign rom_addr     = addr_q;
    assign busy         = (state_q == SFX_PLAY);
    assign cur_id       = id_q;
    assign done         = done_w;

endmodule
